// File: rtl/area_sched_if.sv
// Job, calculator, result and status signals of the area scheduler.
// The slave modport is the scheduler's view; master is the surrounding system.
interface area_sched_if;
    logic        box_valid;
    logic        box_ready;
    logic [9:0]  box_x0, box_y0, box_x1, box_y1;
    logic [3:0]  box_id;

    logic        calc_start;
    logic [9:0]  calc_x0, calc_y0, calc_x1, calc_y1;
    logic        calc_done;
    logic [19:0] calc_area;

    logic        res_valid;
    logic        res_ready;
    logic [3:0]  res_id;
    logic [19:0] res_area;
    logic        res_timeout;

    logic        busy;
    logic        clear_max;
    logic        max_valid;
    logic [19:0] max_area;
    logic [3:0]  max_id;

    modport slave (
        input  box_valid, box_x0, box_y0, box_x1, box_y1, box_id,
        input  calc_done, calc_area, res_ready, clear_max,
        output box_ready, calc_start, calc_x0, calc_y0, calc_x1, calc_y1,
        output res_valid, res_id, res_area, res_timeout,
        output busy, max_valid, max_area, max_id
    );

    modport master (
        output box_valid, box_x0, box_y0, box_x1, box_y1, box_id,
        output calc_done, calc_area, res_ready, clear_max,
        input  box_ready, calc_start, calc_x0, calc_y0, calc_x1, calc_y1,
        input  res_valid, res_id, res_area, res_timeout,
        input  busy, max_valid, max_area, max_id
    );
endinterface

// File: rtl/area_scheduler.sv
// Queues bounding-box jobs, runs each through an external area calculator
// under a watchdog, reports results in order and tracks the largest area.
module area_scheduler #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 4000000
) (
    input logic        clk,
    input logic        reset,
    area_sched_if.slave bus
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_INC = (AW+1)'(1);
    localparam logic [23:0] WD_LAST = 24'(TIMEOUT - 1);

    typedef struct packed {
        logic [9:0] x0, y0, x1, y1;
        logic [3:0] id;
    } job_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, REPORT} state_t;

    state_t      state, next_state;
    job_t        fifo [DEPTH];
    job_t        head, job;
    logic [AW:0] wr_ptr, rd_ptr;
    logic        full, empty, push, pop, degenerate, res_hs, take_max;
    logic        start_c, valid_c;
    logic [23:0] wd;
    logic [19:0] area_q;
    logic        timeout_q;

    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty      = (wr_ptr == rd_ptr);
    assign push       = bus.box_valid && !full;
    assign pop        = (state == IDLE) && !empty;
    assign head       = fifo[rd_ptr[AW-1:0]];
    assign degenerate = (head.x0 > head.x1) || (head.y0 > head.y1);
    assign res_hs     = (state == REPORT) && bus.res_ready;
    // While clearing, any completed job is the new maximum.
    assign take_max   = res_hs && !timeout_q &&
                        (bus.clear_max || !bus.max_valid || area_q > bus.max_area);

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr[AW-1:0]] <= '{bus.box_x0, bus.box_y0, bus.box_x1, bus.box_y1, bus.box_id};
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        start_c    = 1'b0;
        valid_c    = 1'b0;
        case (state)
            IDLE:   if (!empty) next_state = degenerate ? REPORT : ISSUE;
            ISSUE: begin
                start_c    = 1'b1;
                next_state = WAIT;
            end
            WAIT:   if (bus.calc_done || wd == WD_LAST) next_state = REPORT;
            REPORT: begin
                valid_c = 1'b1;
                if (bus.res_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            job           <= '0;
            wd            <= '0;
            area_q        <= '0;
            timeout_q     <= 1'b0;
            bus.max_valid <= 1'b0;
            bus.max_area  <= '0;
            bus.max_id    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_INC;
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_INC;
                job       <= head;
                area_q    <= '0;
                timeout_q <= 1'b0;
            end
            if (state == ISSUE) wd <= '0;
            if (state == WAIT) begin
                wd <= wd + 24'd1;
                // A done arriving on the last watchdog cycle still counts.
                if (bus.calc_done) begin
                    area_q    <= bus.calc_area;
                    timeout_q <= 1'b0;
                end else if (wd == WD_LAST) begin
                    area_q    <= '0;
                    timeout_q <= 1'b1;
                end
            end
            if (take_max) begin
                bus.max_valid <= 1'b1;
                bus.max_area  <= area_q;
                bus.max_id    <= job.id;
            end else if (bus.clear_max) begin
                bus.max_valid <= 1'b0;
                bus.max_area  <= '0;
                bus.max_id    <= '0;
            end
        end
    end

    assign bus.box_ready   = !full;
    assign bus.calc_start  = start_c;
    assign bus.calc_x0     = job.x0;
    assign bus.calc_y0     = job.y0;
    assign bus.calc_x1     = job.x1;
    assign bus.calc_y1     = job.y1;
    assign bus.res_valid   = valid_c;
    assign bus.res_id      = job.id;
    assign bus.res_area    = area_q;
    assign bus.res_timeout = timeout_q;
    assign bus.busy        = !empty || (state != IDLE);
endmodule
